memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 8, word address width
- DATA_W, 32, data width
- FIFO_DEPTH, 2, command queue depth
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. The block has one clock; reset is asynchronous and active-low.
- clock, in, 1, sole clock, rising edge
- clear_n, in, 1, asynchronous active-low reset
- cmd_valid, in, 1, CPU command present
- cmd_ready, out, 1, command queue not full
- cmd_write, in, 1, 1 = write, 0 = read
- cmd_addr, in, ADDR_W, word address
- cmd_wdata, in, DATA_W, write data
- resp_valid, out, 1, one-cycle completion pulse
- resp_write, out, 1, type of the completed command
- resp_rdata, out, DATA_W, read data; holds its value until the next read completes
- busy, out, 1, FSM not IDLE or queue non-empty
- ram_address, out, ADDR_W, address to RAM
- ram_data_in, out, DATA_W, write data to RAM
- ram_write, out, 1, RAM write strobe; RAM acts on the rising edge
- ram_read, out, 1, RAM read strobe; RAM acts on the rising edge
- ram_data_out, in, DATA_W, RAM read data; valid after the ram_read rising edge

Function
REQ-003 A command SHALL be accepted on a rising clock edge where cmd_valid && cmd_ready; it is then pushed into the queue.
REQ-004 cmd_ready SHALL be 1 when the queue count < FIFO_DEPTH; a push while full is impossible by definition.
REQ-005 The FSM SHALL have these states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-006 FSM transitions SHALL be as follows.
- IDLE -> SETUP when the queue is non-empty; the head entry is popped and latched into ram_address, ram_data_in and the op register.
- SETUP -> STROBE, STROBE -> HOLD, HOLD -> DONE, each unconditionally.
- DONE -> SETUP if the queue is non-empty (pop again); otherwise DONE -> IDLE.
REQ-007 Strobe behaviour SHALL be as follows.
- ram_write (for writes) or ram_read (for reads) is 1 only in STROBE; both are 0 in all other states.
- The two strobes are never high together.
- All strobes are registered outputs, so they are glitch-free.
REQ-008 ram_address and ram_data_in SHALL remain stable from SETUP through DONE.
REQ-009 For a read, resp_rdata SHALL capture ram_data_out on the edge leaving HOLD. For a write, resp_rdata is unchanged.
REQ-010 resp_valid SHALL be 1 for exactly the DONE cycle, and resp_write SHALL reflect the completed op.
REQ-011 Latency SHALL be as follows.
- A command accepted at edge T into an empty, idle controller reaches SETUP at T+1, STROBE at T+2, HOLD at T+3 and DONE at T+4.
- Back-to-back commands complete every 4 cycles.
REQ-012 A simultaneous push and pop SHALL leave the count unchanged and SHALL be legal at any count from 1 to FIFO_DEPTH.
REQ-013 A push into an empty queue while the FSM is in IDLE SHALL not be popped in the same cycle.
REQ-014 Queue pointers SHALL wrap modulo FIFO_DEPTH, and command order SHALL be strictly FIFO.
REQ-015 Commands with no resp_valid backpressure SHALL be the case: the CPU must accept every pulse.

Reset
REQ-016 Asserting clear_n = 0 SHALL immediately produce the following, without waiting for a clock edge.
- FSM goes to IDLE and the queue empties.
- cmd_ready = 1.
- resp_valid, ram_write, ram_read, busy, resp_write = 0.
- ram_address, ram_data_in, resp_rdata = 0.
REQ-017 Reset during STROBE SHALL drop the strobe low. A rising edge that already occurred stands; no response is issued for that command, and queued commands are discarded.
REQ-018 After clear_n is deasserted, the first accept SHALL be allowed on the next clock edge.

Structure
REQ-019 A shared package mem_pkg SHALL hold the following.
- The state enum {IDLE, SETUP, STROBE, HOLD, DONE}.
- ADDR_W, DATA_W and FIFO_DEPTH defaults.
- The command struct {write, addr, wdata}.
REQ-020 One sub-module, cmd_fifo, SHALL implement the queue with push, pop, full, empty and count, using the same clock and clear_n.

Verification
REQ-021 The bench SHALL cover these directed scenarios, using a behavioural RAM model driven by the strobes.
- Single write: write 0x12 <- 0xDEADBEEF accepted at T -> ram_write high only at T+2, resp_valid at T+4 with resp_write = 1, and model memory[0x12] = 0xDEADBEEF.
- Single read: after the write above, read 0x12 -> ram_read high only at T+2, resp_valid at T+4 with resp_rdata = 0xDEADBEEF.
- Queue full: three commands offered back-to-back while busy -> cmd_ready falls after two are queued; the third is accepted only after a pop; responses come out in order, 4 cycles apart.
- Simultaneous push and pop: queue holds 1 entry and the FSM is in DONE -> push and pop occur on the same edge, count stays 1, no loss or duplication.
- Reset mid-operation: clear_n low during HOLD with 1 entry queued -> all outputs reach reset values with no clock edge, no resp_valid, and the queued command is never issued.
- Wrap-around: ten alternating write/read commands to addresses 0x00 and 0xFF -> all data correct and pointers wrap cleanly.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory controller and its command queue.
package mem_pkg;

    localparam int MEM_ADDR_W     = 8;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: circular buffer with wrapping pointers and an occupancy count.
module cmd_fifo
    import mem_pkg::*;
#(
    parameter int  DEPTH = MEM_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             push,
    input  cmd_t             push_data,
    input  logic             pop,
    output cmd_t             pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    cmd_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A push is taken at full only when a pop frees the slot on the same edge.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == CNT_W'(0));
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Pointer, count and storage update.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/memory_controller.sv
// Queued CPU-to-RAM controller: SETUP/STROBE/HOLD/DONE sequence per command with registered strobes.
module memory_controller
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIFO_DEPTH = MEM_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write,
    output logic              ram_read,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state_r;
    state_t            state_nxt_s;
    cmd_t              push_cmd_s;
    cmd_t              head_cmd_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              op_write_r;
    logic [ADDR_W-1:0] ram_address_r;
    logic [DATA_W-1:0] ram_data_in_r;
    logic              ram_write_r;
    logic              ram_read_r;
    logic              resp_valid_r;
    logic              resp_write_r;
    logic [DATA_W-1:0] resp_rdata_r;

    assign push_cmd_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign push_s     = cmd_valid && cmd_ready;
    // Heads are only taken when the sequencer can start a new command.
    assign pop_s      = ((state_r == IDLE) || (state_r == DONE)) && !fifo_empty_s;

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .clear_n   (clear_n),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (head_cmd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Next-state selection for the command sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = fifo_empty_s ? IDLE : SETUP;
            SETUP:   state_nxt_s = STROBE;
            STROBE:  state_nxt_s = HOLD;
            HOLD:    state_nxt_s = DONE;
            DONE:    state_nxt_s = fifo_empty_s ? IDLE : SETUP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer state, latched command and registered RAM/response outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r       <= IDLE;
            op_write_r    <= 1'b0;
            ram_address_r <= '0;
            ram_data_in_r <= '0;
            ram_write_r   <= 1'b0;
            ram_read_r    <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_write_r  <= 1'b0;
            resp_rdata_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                op_write_r    <= head_cmd_s.write;
                ram_address_r <= head_cmd_s.addr;
                ram_data_in_r <= head_cmd_s.wdata;
            end
            // Strobes are registered so they are high exactly during STROBE.
            ram_write_r  <= (state_r == SETUP) && op_write_r;
            ram_read_r   <= (state_r == SETUP) && !op_write_r;
            resp_valid_r <= (state_r == HOLD);
            if (state_r == HOLD) begin
                resp_write_r <= op_write_r;
                if (!op_write_r) begin
                    resp_rdata_r <= ram_data_out;
                end
            end
        end
    end

    assign cmd_ready   = !fifo_full_s;
    assign busy        = (state_r != IDLE) || (fifo_count_s != CNT_W'(0));
    assign ram_address = ram_address_r;
    assign ram_data_in = ram_data_in_r;
    assign ram_write   = ram_write_r;
    assign ram_read    = ram_read_r;
    assign resp_valid  = resp_valid_r;
    assign resp_write  = resp_write_r;
    assign resp_rdata  = resp_rdata_r;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a behavioural RAM driven by the strobes.
module tb_memory_controller;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [7:0]  ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write;
    logic        ram_read;
    logic [31:0] ram_data_out;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int strobe_cnt = 0;
    int both_cnt   = 0;
    int          resp_cyc [$];
    logic        resp_wr  [$];
    logic [31:0] resp_dat [$];
    logic [31:0] ram_mem [256];

    memory_controller dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .resp_valid   (resp_valid),
        .resp_write   (resp_write),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .ram_data_out (ram_data_out)
    );

    always #5 clock = ~clock;

    // Cycle stamp: value after edge N is N.
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM acting on the strobes at the rising edge.
    always @(posedge clock) begin
        if (ram_write) ram_mem[ram_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= ram_mem[ram_address];
    end

    // Response and strobe monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (resp_valid) begin
            resp_cyc.push_back(cyc);
            resp_wr.push_back(resp_write);
            resp_dat.push_back(resp_rdata);
        end
        if (ram_write || ram_read) strobe_cnt <= strobe_cnt + 1;
        if (ram_write && ram_read) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offer one command; t returns the edge number at which it was accepted.
    task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d, output int t);
        logic rdy;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clock);
            rdy = cmd_ready;
            @(posedge clock);
            #1;
            if (rdy) t = cyc;
        end
        cmd_valid = 1'b0;
        check("accepted", 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_resps(input int base, input int n);
        for (int i = 0; i < 200 && resp_cyc.size() < base + n; i++) step(1);
        check("resp_count", 32'(resp_cyc.size() - base), 32'(n));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        check({tag, "_resp_write"},  32'(resp_write),  32'd0);
        check({tag, "_ram_write"},   32'(ram_write),   32'd0);
        check({tag, "_ram_read"},    32'(ram_read),    32'd0);
        check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        check({tag, "_ram_data_in"}, ram_data_in,      32'd0);
        check({tag, "_resp_rdata"},  resp_rdata,       32'd0);
    endtask

    // One command into an idle controller, checked cycle by cycle.
    task automatic single(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd);
        int t;
        send(wr, a, d, t);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check($sformatf("single_k%0d_ram_write", k), 32'(ram_write), 32'(wr && k == 2));
            check($sformatf("single_k%0d_ram_read", k), 32'(ram_read), 32'(!wr && k == 2));
            check($sformatf("single_k%0d_resp_valid", k), 32'(resp_valid), 32'(k == 4));
            if (k <= 4) check($sformatf("single_k%0d_addr", k), 32'(ram_address), 32'(a));
            if (k >= 4) check($sformatf("single_k%0d_rdata", k), resp_rdata, exp_rd);
            if (k == 4) check("single_resp_write", 32'(resp_write), 32'(wr));
        end
    endtask

    initial begin
        int tp, ta, tb, tc, tx, ty, tz, tw, tv, tr, trel, t0, base, s0, r0;
        int          tw_arr [10];
        logic [31:0] last_rd;
        logic [31:0] exp_d;

        clear_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h0;
        #2;
        reset_checks("por");
        step(2);
        clear_n = 1'b1;

        // Single write then single read of the same word.
        single(1'b1, 8'h12, 32'hDEADBEEF, 32'h0);
        check("model_mem_12", ram_mem[8'h12], 32'hDEADBEEF);
        single(1'b0, 8'h12, 32'h0, 32'hDEADBEEF);

        // Queue full: P starts, A and B fill the queue, C waits for a pop.
        base = resp_cyc.size();
        send(1'b1, 8'h30, 32'h11111111, tp);
        send(1'b0, 8'h30, 32'h0, ta);
        send(1'b1, 8'h31, 32'h22222222, tb);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        send(1'b0, 8'h31, 32'h0, tc);
        check("full_ta", 32'(ta), 32'(tp + 1));
        check("full_tb", 32'(tb), 32'(tp + 2));
        check("full_tc", 32'(tc), 32'(tp + 6));
        wait_resps(base, 4);
        if (resp_cyc.size() >= base + 4) begin
            check("full_c0", 32'(resp_cyc[base]),     32'(tp + 4));
            check("full_c1", 32'(resp_cyc[base + 1]), 32'(tp + 8));
            check("full_c2", 32'(resp_cyc[base + 2]), 32'(tp + 12));
            check("full_c3", 32'(resp_cyc[base + 3]), 32'(tp + 16));
            check("full_w0", 32'(resp_wr[base]),     32'd1);
            check("full_w1", 32'(resp_wr[base + 1]), 32'd0);
            check("full_w3", 32'(resp_wr[base + 3]), 32'd0);
            check("full_d0", resp_dat[base],     32'hDEADBEEF);
            check("full_d1", resp_dat[base + 1], 32'h11111111);
            check("full_d2", resp_dat[base + 2], 32'h11111111);
            check("full_d3", resp_dat[base + 3], 32'h22222222);
        end

        // Push and pop on the same edge while in DONE with one entry queued.
        step(3);
        base = resp_cyc.size();
        send(1'b1, 8'h50, 32'h33333333, tx);
        send(1'b0, 8'h50, 32'h0, ty);
        step(3);
        check("pp_busy_done", 32'(busy), 32'd1);
        check("pp_resp_valid_done", 32'(resp_valid), 32'd1);
        send(1'b1, 8'h51, 32'h44444444, tz);
        check("pp_tz", 32'(tz), 32'(tx + 5));
        check("pp_ready_after", 32'(cmd_ready), 32'd1);
        wait_resps(base, 3);
        step(6);
        check("pp_no_dup", 32'(resp_cyc.size() - base), 32'd3);
        if (resp_cyc.size() >= base + 3) begin
            check("pp_c1", 32'(resp_cyc[base + 1]), 32'(tx + 8));
            check("pp_c2", 32'(resp_cyc[base + 2]), 32'(tx + 12));
            check("pp_d1", resp_dat[base + 1], 32'h33333333);
            check("pp_w2", 32'(resp_wr[base + 2]), 32'd1);
        end
        check("pp_mem51", ram_mem[8'h51], 32'h44444444);

        // Reset during HOLD with one command still queued.
        send(1'b1, 8'h40, 32'hAAAA5555, tw);
        send(1'b1, 8'h41, 32'h5A5A5A5A, tv);
        step(2);
        check("rst_at_hold", 32'(cyc), 32'(tw + 3));
        #1;
        s0 = strobe_cnt;
        r0 = resp_cyc.size();
        clear_n = 1'b0;
        #1;
        reset_checks("mid");
        step(2);
        clear_n = 1'b1;
        trel = cyc;
        send(1'b0, 8'h40, 32'h0, tr);
        check("rst_first_accept", 32'(tr), 32'(trel + 1));
        wait_resps(r0, 1);
        step(4);
        check("rst_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("rst_resp_total", 32'(resp_cyc.size() - r0), 32'd1);
        if (resp_cyc.size() >= r0 + 1) begin
            check("rst_read_c", 32'(resp_cyc[r0]), 32'(tr + 4));
            check("rst_read_d", resp_dat[r0], 32'hAAAA5555);
        end

        // Wrap-around: alternating write/read on 0x00 and 0xFF.
        base = resp_cyc.size();
        for (int i = 0; i < 10; i++) begin
            send((i % 2) == 0, ((i / 2) % 2) ? 8'hFF : 8'h00, 32'hC0DE0000 + 32'(i), tw_arr[i]);
        end
        t0 = tw_arr[0];
        wait_resps(base, 10);
        last_rd = 32'hAAAA5555;
        if (resp_cyc.size() >= base + 10) begin
            for (int i = 0; i < 10; i++) begin
                exp_d = ((i % 2) == 0) ? last_rd : 32'hC0DE0000 + 32'(i - 1);
                last_rd = exp_d;
                check($sformatf("wrap_c%0d", i), 32'(resp_cyc[base + i]), 32'(t0 + 4 + 4 * i));
                check($sformatf("wrap_w%0d", i), 32'(resp_wr[base + i]), 32'((i % 2) == 0));
                check($sformatf("wrap_d%0d", i), resp_dat[base + i], exp_d);
            end
        end
        check("wrap_mem00", ram_mem[8'h00], 32'hC0DE0008);
        check("wrap_memff", ram_mem[8'hFF], 32'hC0DE0006);

        step(2);
        check("strobes_exclusive", 32'(both_cnt), 32'd0);
        check("idle_at_end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
